// File: rtl/vsdriscv_dmem_responder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : vsdriscv_dmem_responder
// Description : 64-bit doubleword data memory answering the CPU load/store
//               port over valid/ready request and response channels.
// Revision    : 1.0 - initial release
// ============================================================================
module vsdriscv_dmem_responder #(
    parameter int ADDR_W    = 12,
    parameter int DEPTH     = 512,
    parameter int LATENCY   = 2,
    parameter     INIT_FILE = ""
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [63:0]       req_wdata,
    input  logic [7:0]        req_wstrb,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [63:0]       rsp_rdata,
    output logic              rsp_err
);

    localparam int CNT_W  = (LATENCY > 2) ? $clog2(LATENCY) : 1;
    localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0] C_CNT_LOAD = CNT_W'(LATENCY - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t              r_state;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_we;
    logic [ADDR_W-1:0]   r_addr;
    logic [63:0]         r_wdata;
    logic [7:0]          r_wstrb;

    logic [63:0]         mem [DEPTH];

    logic                w_misaligned;
    logic                w_oor;
    logic                w_err;
    logic [MEM_AW-1:0]   w_idx;
    logic                w_fire;
    logic                w_commit;

    assign w_misaligned = |r_addr[2:0];
    assign w_oor        = 32'(r_addr[ADDR_W-1:3]) >= DEPTH;
    assign w_err        = w_misaligned | w_oor;
    assign w_idx        = MEM_AW'(r_addr[ADDR_W-1:3]);
    // BUSY always lasts at least one cycle, so RESP is entered exactly
    // LATENCY edges after the accept edge for every legal LATENCY.
    assign w_fire       = (r_state == S_BUSY) && (r_cnt == '0);
    assign w_commit     = w_fire && r_we && !w_err;

    // Memory has no reset; a reset on the commit edge drops the store.
    always_ff @(posedge clk) begin
        if (!reset && w_commit) begin
            for (int b = 0; b < 8; b++) begin
                if (r_wstrb[b]) begin
                    mem[w_idx][8*b +: 8] <= r_wdata[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_we      <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid && req_ready) begin
                        r_we      <= req_we;
                        r_addr    <= req_addr;
                        r_wdata   <= req_wdata;
                        r_wstrb   <= req_wstrb;
                        r_cnt     <= C_CNT_LOAD;
                        req_ready <= 1'b0;
                        r_state   <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    if (r_cnt == '0) begin
                        r_state   <= S_RESP;
                        rsp_valid <= 1'b1;
                        rsp_err   <= w_err;
                        rsp_rdata <= (!w_err && !r_we) ? mem[w_idx] : 64'd0;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        r_state   <= S_IDLE;
                        rsp_valid <= 1'b0;
                        rsp_rdata <= '0;
                        rsp_err   <= 1'b0;
                        req_ready <= 1'b1;
                    end
                end
                default: begin
                    r_state   <= S_IDLE;
                    req_ready <= 1'b1;
                    rsp_valid <= 1'b0;
                    rsp_rdata <= '0;
                    rsp_err   <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_vsdriscv_dmem_responder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_vsdriscv_dmem_responder
// Description : Self-checking bench; four responders with LATENCY 1..4
//               compared against a word-array reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vsdriscv_dmem_responder;

    localparam int N        = 4;
    localparam int DEPTH_TB = 256;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid [N];
    logic        req_ready [N];
    logic        req_we    [N];
    logic [11:0] req_addr  [N];
    logic [63:0] req_wdata [N];
    logic [7:0]  req_wstrb [N];
    logic        rsp_valid [N];
    logic        rsp_ready [N];
    logic [63:0] rsp_rdata [N];
    logic        rsp_err   [N];

    always #5 clk = ~clk;

    generate
        for (genvar g = 0; g < N; g++) begin : g_dut
            vsdriscv_dmem_responder #(
                .ADDR_W(12), .DEPTH(DEPTH_TB), .LATENCY(g + 1), .INIT_FILE("")
            ) u_dut (
                .clk(clk), .reset(reset),
                .req_valid(req_valid[g]), .req_ready(req_ready[g]),
                .req_we(req_we[g]), .req_addr(req_addr[g]),
                .req_wdata(req_wdata[g]), .req_wstrb(req_wstrb[g]),
                .rsp_valid(rsp_valid[g]), .rsp_ready(rsp_ready[g]),
                .rsp_rdata(rsp_rdata[g]), .rsp_err(rsp_err[g])
            );
        end
    endgenerate

    int          checks = 0;
    int          errors = 0;
    logic [63:0] ref_mem [N][DEPTH_TB];
    logic [63:0] exp_rdata;
    logic        exp_err;

    task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%h expected 0x%h", tag, obs, exp);
        end
    endtask

    // Reference: a plain word array, updated in program order.
    task automatic model(int i, logic we, logic [11:0] a, logic [63:0] wd, logic [7:0] ws);
        int w;
        w         = int'(a) / 8;
        exp_err   = (int'(a) % 8 != 0) || (w >= DEPTH_TB);
        exp_rdata = 64'd0;
        if (!exp_err) begin
            if (we) begin
                for (int b = 0; b < 8; b++)
                    if (ws[b]) ref_mem[i][w][8*b +: 8] = wd[8*b +: 8];
            end else begin
                exp_rdata = ref_mem[i][w];
            end
        end
    endtask

    task automatic start(int i, logic we, logic [11:0] a, logic [63:0] wd, logic [7:0] ws);
        int n;
        n = 0;
        while (!req_ready[i] && n < 100) begin @(posedge clk); #1; n++; end
        check($sformatf("req_ready_before_accept[%0d]", i), 64'(req_ready[i]), 64'd1);
        req_valid[i] = 1'b1; req_we[i] = we; req_addr[i] = a;
        req_wdata[i] = wd;   req_wstrb[i] = ws;
        @(posedge clk); #1;
        req_valid[i] = 1'b0;
        model(i, we, a, wd, ws);
        n = 0;
        while (!rsp_valid[i] && n < 100) begin @(posedge clk); #1; n++; end
        check($sformatf("latency[%0d] addr=%h", i, a), 64'(n), 64'(i + 1));
        check($sformatf("rdata[%0d] addr=%h we=%0b", i, a, we), rsp_rdata[i], exp_rdata);
        check($sformatf("err[%0d] addr=%h", i, a), 64'(rsp_err[i]), 64'(exp_err));
    endtask

    // mode 0: quiet, 1: ignored junk requests during stall, 2: caller holds a pending request
    task automatic finish(int i, int stall, int mode);
        for (int k = 0; k < stall; k++) begin
            rsp_ready[i] = 1'b0;
            if (mode == 1) begin
                req_valid[i] = 1'b1;
                req_we[i]    = 1'($urandom);
                req_addr[i]  = 12'($urandom);
                req_wdata[i] = {$urandom, $urandom};
                req_wstrb[i] = 8'($urandom);
            end
            @(posedge clk); #1;
            check($sformatf("stall_valid[%0d]", i), 64'(rsp_valid[i]), 64'd1);
            check($sformatf("stall_rdata[%0d]", i), rsp_rdata[i], exp_rdata);
            check($sformatf("stall_err[%0d]", i), 64'(rsp_err[i]), 64'(exp_err));
            check($sformatf("stall_req_ready[%0d]", i), 64'(req_ready[i]), 64'd0);
        end
        rsp_ready[i] = 1'b1;
        @(posedge clk); #1;
        rsp_ready[i] = 1'b0;
        if (mode != 2) req_valid[i] = 1'b0;
        check($sformatf("post_hs_valid[%0d]", i), 64'(rsp_valid[i]), 64'd0);
        check($sformatf("post_hs_rdata[%0d]", i), rsp_rdata[i], 64'd0);
        check($sformatf("post_hs_err[%0d]", i), 64'(rsp_err[i]), 64'd0);
        check($sformatf("post_hs_req_ready[%0d]", i), 64'(req_ready[i]), 64'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        logic [11:0] a;
        for (int i = 0; i < N; i++) begin
            req_valid[i] = 1'b0; req_we[i] = 1'b0; req_addr[i] = '0;
            req_wdata[i] = '0;   req_wstrb[i] = '0; rsp_ready[i] = 1'b0;
        end

        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        for (int i = 0; i < N; i++) begin
            check($sformatf("rst_req_ready[%0d]", i), 64'(req_ready[i]), 64'd1);
            check($sformatf("rst_rsp_valid[%0d]", i), 64'(rsp_valid[i]), 64'd0);
            check($sformatf("rst_rsp_err[%0d]", i), 64'(rsp_err[i]), 64'd0);
            check($sformatf("rst_rsp_rdata[%0d]", i), rsp_rdata[i], 64'd0);
        end

        // Basic store/load, overlapping byte-strobe merge, misaligned store
        for (int i = 0; i < N; i++) begin
            start(i, 1'b1, 12'h010, 64'h00000000DEADBEEF, 8'hFF); finish(i, 0, 0);
            start(i, 1'b0, 12'h010, 64'd0, 8'h00);                finish(i, 0, 0);
            check($sformatf("deadbeef_const[%0d]", i), ref_mem[i][2], 64'h00000000DEADBEEF);
            start(i, 1'b1, 12'h018, 64'hFFFFFFFFFFFFFFFF, 8'hFF); finish(i, 0, 0);
            start(i, 1'b1, 12'h018, 64'h1122334455667788, 8'h0F); finish(i, 0, 0);
            start(i, 1'b0, 12'h018, 64'd0, 8'h00);                finish(i, 0, 0);
            start(i, 1'b1, 12'h014, 64'h0123456789ABCDEF, 8'hFF); finish(i, 0, 0);
            start(i, 1'b0, 12'h010, 64'd0, 8'h00);                finish(i, 0, 0);
        end

        // Response stalled 5 cycles while a second request waits
        start(1, 1'b0, 12'h018, 64'd0, 8'h00);
        req_valid[1] = 1'b1; req_we[1] = 1'b0; req_addr[1] = 12'h010;
        req_wdata[1] = 64'd0; req_wstrb[1] = 8'h00;
        finish(1, 5, 2);
        start(1, 1'b0, 12'h010, 64'd0, 8'h00);
        finish(1, 0, 0);

        // Reset one cycle after accepting a store drops it
        start(2, 1'b1, 12'h020, 64'd0, 8'hFF); finish(2, 0, 0);
        req_valid[2] = 1'b1; req_we[2] = 1'b1; req_addr[2] = 12'h020;
        req_wdata[2] = 64'hAAAAAAAAAAAAAAAA; req_wstrb[2] = 8'hFF;
        @(posedge clk); #1;
        req_valid[2] = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("abort_req_ready", 64'(req_ready[2]), 64'd1);
        for (int k = 0; k < 5; k++) begin
            check("abort_no_rsp_valid", 64'(rsp_valid[2]), 64'd0);
            @(posedge clk); #1;
        end
        start(2, 1'b0, 12'h020, 64'd0, 8'h00); finish(2, 0, 0);

        // Randomized traffic against the reference model
        for (int i = 0; i < N; i++) begin
            for (int w = 0; w < 16; w++) begin
                start(i, 1'b1, 12'(w * 8), {$urandom, $urandom}, 8'hFF);
                finish(i, 0, 0);
            end
            for (int k = 0; k < 40; k++) begin
                case ($urandom % 8)
                    0:       a = 12'($urandom_range(15) * 8 + $urandom_range(7, 1));
                    1:       a = 12'(12'h800 + $urandom_range(255) * 8);
                    default: a = 12'($urandom_range(15) * 8);
                endcase
                start(i, 1'($urandom), a, {$urandom, $urandom}, 8'($urandom));
                finish(i, int'($urandom % 4), int'($urandom % 2));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
